// File: rtl/dram_resp_buffer.sv
// Elastic burst FIFO between the DRAM model's valid-only response pulses and a ready/valid consumer.
// Optional occupancy statistics (resp_total, hi_water) are built when DRAM_RESP_BUFFER_STATS_EN is defined.
module dram_resp_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WORDS = 16,
  parameter int unsigned TAG_W = 32,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   in_rdata,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic [TAG_W-1:0]      in_streamId,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   out_rdata,
  output logic [TAG_W-1:0]      out_tag,
  output logic [TAG_W-1:0]      out_streamId,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow
`ifdef DRAM_RESP_BUFFER_STATS_EN
  ,
  output logic [31:0]           resp_total,
  output logic [CNT_W-1:0]      hi_water
`endif
);

  localparam int unsigned DATA_W = 32 * WORDS;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_rdata [DEPTH];
  logic [TAG_W-1:0]  mem_tag   [DEPTH];
  logic [TAG_W-1:0]  mem_sid   [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             push, pop, drop;

  // in_ready/out_valid are flops, so neither depends combinationally on out_ready
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  assign drop = in_valid & ~in_ready;

  // Next-state pointers and occupancy; clear overrides any push/pop in the same cycle
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    if (clear) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) begin
        wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_nxt;
      wr_ptr    <= wr_ptr_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      in_ready  <= (count_nxt != FULL_CNT);
      overflow  <= clear ? 1'b0 : (overflow | drop);
    end
  end

  // Burst storage is intentionally not reset; contents are only observed while out_valid is high
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem_rdata[wr_ptr] <= in_rdata;
      mem_tag[wr_ptr]   <= in_tag;
      mem_sid[wr_ptr]   <= in_streamId;
    end
  end

  assign out_rdata    = mem_rdata[rd_ptr];
  assign out_tag      = mem_tag[rd_ptr];
  assign out_streamId = mem_sid[rd_ptr];

`ifdef DRAM_RESP_BUFFER_STATS_EN
  // Accepted-push total and peak occupancy, tracked alongside count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_total <= '0;
      hi_water   <= '0;
    end else if (clear) begin
      resp_total <= '0;
      hi_water   <= '0;
    end else begin
      resp_total <= resp_total + 32'(push);
      if (count_nxt > hi_water) begin
        hi_water <= count_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dram_resp_buffer.sv
// Self-checking bench for dram_resp_buffer: DEPTH=8 and DEPTH=5 instances share one stimulus stream
// and are compared every cycle against a queue-based reference model.
module tb_dram_resp_buffer;

  localparam int unsigned WORDS = 16;
  localparam int unsigned TAG_W = 32;
  localparam int unsigned DW    = 32 * WORDS;
  localparam int unsigned D0    = 8;
  localparam int unsigned D1    = 5;
  localparam int unsigned C0    = $clog2(D0 + 1);
  localparam int unsigned C1    = $clog2(D1 + 1);

  logic             clock, reset, clear, in_valid, out_ready;
  logic [DW-1:0]    in_rdata;
  logic [TAG_W-1:0] in_tag, in_sid;

  logic             ir0, ov0, of0, ir1, ov1, of1;
  logic [DW-1:0]    rd0, rd1;
  logic [TAG_W-1:0] tg0, sd0, tg1, sd1;
  logic [C0-1:0]    cnt0;
  logic [C1-1:0]    cnt1;
`ifdef DRAM_RESP_BUFFER_STATS_EN
  logic [31:0]      tot0, tot1;
  logic [C0-1:0]    hw0;
  logic [C1-1:0]    hw1;
`endif

  dram_resp_buffer #(.DEPTH(D0), .WORDS(WORDS), .TAG_W(TAG_W)) u_d8 (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(ir0), .in_rdata(in_rdata), .in_tag(in_tag), .in_streamId(in_sid),
    .out_valid(ov0), .out_ready(out_ready), .out_rdata(rd0), .out_tag(tg0), .out_streamId(sd0),
    .count(cnt0), .overflow(of0)
`ifdef DRAM_RESP_BUFFER_STATS_EN
    , .resp_total(tot0), .hi_water(hw0)
`endif
  );

  dram_resp_buffer #(.DEPTH(D1), .WORDS(WORDS), .TAG_W(TAG_W)) u_d5 (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(ir1), .in_rdata(in_rdata), .in_tag(in_tag), .in_streamId(in_sid),
    .out_valid(ov1), .out_ready(out_ready), .out_rdata(rd1), .out_tag(tg1), .out_streamId(sd1),
    .count(cnt1), .overflow(of1)
`ifdef DRAM_RESP_BUFFER_STATS_EN
    , .resp_total(tot1), .hi_water(hw1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0]    d;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] sid;
  } ent_t;

  ent_t        mq [2][$];
  int          mdep [2];
  bit          movf [2];
  logic [31:0] mtot [2];
  int          mhw  [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      movf[k] = 1'b0;
      mtot[k] = '0;
      mhw[k]  = 0;
    end
  endtask

  // Reference behaviour at one rising edge, using the inputs currently applied
  task automatic model_edge();
    ent_t e;
    bit   full;
    bit   do_pop;
    e.d   = in_rdata;
    e.tag = in_tag;
    e.sid = in_sid;
    if (reset || clear) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        full   = (mq[k].size() == mdep[k]);
        do_pop = (mq[k].size() != 0) && out_ready;
        if (in_valid && full) movf[k] = 1'b1;
        if (do_pop) void'(mq[k].pop_front());
        if (in_valid && !full) begin
          mq[k].push_back(e);
          mtot[k] = mtot[k] + 32'd1;
        end
        if (mq[k].size() > mhw[k]) mhw[k] = mq[k].size();
      end
    end
  endtask

  task automatic check_all();
    logic             ir, ov, of;
    logic [31:0]      cnt;
    logic [DW-1:0]    rd;
    logic [TAG_W-1:0] tg, sd;
    string            p;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        ir = ir0; ov = ov0; of = of0; cnt = 32'(cnt0); rd = rd0; tg = tg0; sd = sd0;
      end else begin
        ir = ir1; ov = ov1; of = of1; cnt = 32'(cnt1); rd = rd1; tg = tg1; sd = sd1;
      end
      p = $sformatf("d%0d_", mdep[k]);
      chk({p, "in_ready"},  DW'(ir),  DW'(mq[k].size() != mdep[k]));
      chk({p, "out_valid"}, DW'(ov),  DW'(mq[k].size() != 0));
      chk({p, "count"},     DW'(cnt), DW'(mq[k].size()));
      chk({p, "overflow"},  DW'(of),  DW'(movf[k]));
      if (mq[k].size() != 0) begin
        chk({p, "out_rdata"},    rd,      mq[k][0].d);
        chk({p, "out_tag"},      DW'(tg), DW'(mq[k][0].tag));
        chk({p, "out_streamId"}, DW'(sd), DW'(mq[k][0].sid));
      end
`ifdef DRAM_RESP_BUFFER_STATS_EN
      chk({p, "resp_total"}, DW'((k == 0) ? tot0 : tot1), DW'(mtot[k]));
      chk({p, "hi_water"},   DW'((k == 0) ? 32'(hw0) : 32'(hw1)), DW'(mhw[k]));
`endif
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input bit r, input logic [TAG_W-1:0] tag);
    in_valid  = v;
    out_ready = r;
    in_tag    = tag;
    in_sid    = $urandom;
    for (int w = 0; w < int'(WORDS); w++) in_rdata[32*w +: 32] = $urandom;
  endtask

  logic [TAG_W-1:0] seen [$];

  initial begin
    mdep[0] = D0;
    mdep[1] = D1;
    model_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rdata = '0; in_tag = '0; in_sid = '0;
    #7;
    check_all();
    #5 reset = 1'b0;

    // Single pass-through
    drive(1'b1, 1'b1, 32'd5);
    for (int w = 0; w < int'(WORDS); w++) in_rdata[32*w +: 32] = 32'h100 + 32'(w);
    step();
    chk("pass_tag",    DW'(tg0), DW'(32'd5));
    chk("pass_word15", DW'(rd0[32*15 +: 32]), DW'(32'h10F));
    chk("pass_cnt1",   DW'(cnt0), DW'(1));
    drive(1'b0, 1'b1, 32'd0);
    step();
    chk("pass_cnt0",   DW'(cnt0), DW'(0));

    // Fill and drop
    for (int t = 0; t < 9; t++) begin
      drive(1'b1, 1'b0, 32'(t));
      step();
    end
    chk("fill_cnt8",  DW'(cnt0), DW'(8));
    chk("fill_ready", DW'(ir0),  DW'(0));
    chk("fill_ovf",   DW'(of0),  DW'(1));
    chk("fill_cnt5",  DW'(cnt1), DW'(5));

    // Full: simultaneous push attempt and pop
    drive(1'b1, 1'b1, 32'd99);
    if (ov0) seen.push_back(tg0);
    step();
    chk("fullsim_cnt", DW'(cnt0), DW'(7));
    chk("fullsim_ovf", DW'(of0),  DW'(1));

    // Drain and confirm order 0..7
    for (int t = 0; t < 10; t++) begin
      drive(1'b0, 1'b1, 32'd0);
      if (ov0) seen.push_back(tg0);
      step();
    end
    chk("drain_len", DW'(seen.size()), DW'(8));
    for (int t = 0; t < seen.size(); t++) chk($sformatf("drain_tag%0d", t), DW'(seen[t]), DW'(t));

    // Clear together with a push
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, 1'b0, 32'(40 + t));
      step();
    end
    drive(1'b1, 1'b1, 32'd77);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_cnt",  DW'(cnt0), DW'(0));
    chk("clear_ovf",  DW'(of0),  DW'(0));
    chk("clear_oval", DW'(ov0),  DW'(0));

    // Wrap-around: push every cycle, pop every other cycle
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'(i % 2), 32'(20 + i));
      step();
      chk("wrap_d5_bound", DW'(cnt1 <= 3'(D1)), DW'(1));
    end

    // Asynchronous reset mid-cycle
    drive(1'b1, 1'b0, 32'd60);
    step();
    #3 reset = 1'b1;
    #1;
    chk("areset_oval0", DW'(ov0), DW'(0));
    chk("areset_oval1", DW'(ov1), DW'(0));
    model_reset();
    check_all();
    drive(1'b0, 1'b0, 32'd0);
    step();
    reset = 1'b0;

`ifdef DRAM_RESP_BUFFER_STATS_EN
    // Ten accepted pushes with peak occupancy four
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'(100 + i));
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 32'(104 + i));
      step();
    end
    chk("stats_total", DW'(tot0), DW'(10));
    chk("stats_hw",    DW'(hw0),  DW'(4));
    drive(1'b0, 1'b0, 32'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("stats_total_clr", DW'(tot0), DW'(0));
    chk("stats_hw_clr",    DW'(hw0),  DW'(0));
`endif

    // Randomized traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom);
      clear = ($urandom_range(0, 49) == 0);
      step();
    end
    clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_resp_buffer.md
Name: dram_resp_buffer

Overview:
- Elastic FIFO between the simulated DRAM response path and the accelerator's DRAM response port.
- The DRAM model pulses one response per cycle (valid only, no backpressure). This block absorbs those pulses and re-presents them to the accelerator with a ready/valid handshake.
- Each entry holds one burst: 16 x 32-bit rdata words, tag and streamId.
- Drops and flags any response that arrives while the FIFO is full.

Parameters:
- DEPTH, 8, number of burst entries; any value >= 2, need not be a power of 2.
- WORDS, 16, 32-bit data words per burst.
- TAG_W, 32, width of tag and of streamId.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush.
- in_valid  in  1  response pulse from the DRAM model.
- in_ready  out  1  space available (not full).
- in_rdata  in  32*WORDS  burst data; word i occupies bits [32*i+31:32*i].
- in_tag  in  TAG_W  request tag.
- in_streamId  in  TAG_W  stream identifier.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_rdata  out  32*WORDS  head entry data.
- out_tag  out  TAG_W  head entry tag.
- out_streamId  out  TAG_W  head entry streamId.
- count  out  CNT_W  current occupancy.
- overflow  out  1  sticky flag: a response was dropped.

Behaviour:
- Reset (async, active-high): rd_ptr=0, wr_ptr=0, count=0, overflow=0, out_valid=0, in_ready=1. Storage array is not reset; out_rdata/out_tag/out_streamId are don't-care while out_valid=0.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It is a registered-state function only, with no combinational path from out_ready.
  - When full, a simultaneous push attempt and pop: the pop proceeds, the push is rejected and overflow sets.
- Drop: in_valid & ~in_ready sets overflow at that edge. The entry is discarded; pointers and count are unchanged.
- overflow clears only on reset or clear.
- out_valid = (count != 0). Outputs read combinationally from storage[rd_ptr].
- Latency: no bypass. A push into an empty FIFO at edge N makes out_valid=1 in the cycle after edge N; data appears on the outputs at the same time.
- Pointers: increment by 1 and wrap DEPTH-1 -> 0 (explicit compare, not power-of-2 masking).
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: unchanged; both pointers advance.
- Empty with out_ready=1 and no push: no change, no underflow.
- clear (sync) takes priority over push and pop in the same cycle:
  - pointers and count return to 0;
  - overflow returns to 0;
  - the push in that cycle is discarded and is not flagged.
- Reset asserted mid-burst stream: all queued entries are lost; the outputs follow the reset values above immediately (asynchronously).
- Ordering is strict FIFO. Tag and streamId travel unchanged with their data. The block performs no reordering and no tag check.

Optional Feature:
- Macro: DRAM_RESP_BUFFER_STATS_EN.
- Defined:
  - Adds output resp_total [31:0]: count of accepted pushes; wraps 0xFFFFFFFF -> 0; dropped responses are not counted.
  - Adds output hi_water [CNT_W-1:0]: maximum count value since the last reset/clear.
  - Both are updated at the same edge as count, reset asynchronously to 0 and zeroed by clear.
- Not defined: neither port nor its registers exist. All other behaviour is identical.

Test Plan:
- Single pass-through: DEPTH=8, one push with tag=5, rdata word i=0x100+i, out_ready=1 → out_valid high exactly one cycle later with tag=5 and word15=0x10F; count goes 0→1→0.
- Fill and drop: 9 consecutive pushes with tags 0..8, out_ready=0 → count=8, in_ready=0, overflow=1. Then drain → tags 0..7 in order; tag 8 never appears.
- Full simultaneous: at count=8, assert in_valid and out_ready together → pop of head succeeds, push rejected, count=7, overflow=1.
- Wrap-around with DEPTH=5: 12 pushes and pops interleaved (push each cycle, out_ready every other cycle) → all accepted tags emerge in order; count never exceeds 5.
- Clear/reset: count=3, then clear together with in_valid → count=0, out_valid=0, overflow=0 next cycle. Async reset asserted mid-cycle → out_valid drops before the next clock edge.
- Stats (macro defined): 10 accepted pushes with peak occupancy 4 → resp_total=10, hi_water=4. After clear → both 0.
